// File: rtl/mem_dump_reader.sv
// Data-memory readback unit: walks a word range through a synchronous read
// port and streams each word, with its address, over a valid/ready interface.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; a zero-length start only pulses done
// READ    | mem_re is high this cycle, memory samples the address
// CAPTURE | read data is valid, latch it into the output holding regs
// SEND    | out_valid high, hold the word until the sink takes it
module mem_dump_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   word_count_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_re_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic                  out_last_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_SEND    = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mem_re_q, mem_re_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic                  out_last_q, out_last_d;
  // One bit wider than the address so a full-memory dump fits.
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;

  // State and datapath registers; reset overrides everything, including a dump in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      remaining_q <= remaining_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_i && (word_count_i != '0)) state_d = ST_READ;
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_SEND;
      ST_SEND:    if (out_ready_i) state_d = out_last_q ? ST_IDLE : ST_READ;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; everything holds unless the state says otherwise.
  always_comb begin
    busy_d      = busy_q;
    done_d      = 1'b0;
    mem_re_d    = mem_re_q;
    mem_addr_d  = mem_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (word_count_i != '0) begin
            busy_d      = 1'b1;
            mem_re_d    = 1'b1;
            mem_addr_d  = base_addr_i;
            remaining_d = word_count_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        mem_re_d = 1'b0;
      end
      ST_CAPTURE: begin
        out_data_d  = mem_rdata_i;
        out_addr_d  = mem_addr_q;
        out_last_d  = (remaining_q == CNT_ONE);
        out_valid_d = 1'b1;
      end
      ST_SEND: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          remaining_d = remaining_q - CNT_ONE;
          if (out_last_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            mem_re_d   = 1'b1;
            // Wraps naturally at the top of memory.
            mem_addr_d = mem_addr_q + ADDR_ONE;
          end
        end
      end
      default: ;
    endcase
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign mem_re_o    = mem_re_q;
  assign mem_addr_o  = mem_addr_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_addr_o  = out_addr_q;
  assign out_last_o  = out_last_q;

endmodule
